// File: rtl/seg_scan_driver_if.sv
// Bus bundle between the value-producing logic and seg_scan_driver.
//   value      : 4*DIGITS hex nibbles, nibble i = value[4i+3:4i]
//   load       : capture value into the pending register this cycle
//   blank_lz   : 1 = suppress leading zero digits
//   dp_mask    : decimal point per digit, sampled live
//   seg        : segments {g,f,e,d,c,b,a}, active high
//   dp         : decimal point of the active digit
//   digit_en   : one-hot digit select, active high
//   frame_tick : one-cycle pulse at each frame start
// master = value producer / pin side, slave = the scan driver.
interface seg_scan_driver_if #(
  parameter int unsigned DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic                load;
  logic                blank_lz;
  logic [DIGITS-1:0]   dp_mask;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   digit_en;
  logic                frame_tick;

  modport master (
    output value, load, blank_lz, dp_mask,
    input  seg, dp, digit_en, frame_tick
  );

  modport slave (
    input  value, load, blank_lz, dp_mask,
    output seg, dp, digit_en, frame_tick
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver with tear-free frame updates,
// per-slot anti-ghosting blanking and optional leading-zero suppression.
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : seg_scan_driver_if.slave (value/load/blank_lz/dp_mask in,
//          seg/dp/digit_en/frame_tick out)
// Parameters: DIGITS (1..8), PRESCALE cycles per slot (>=2),
//             BLANK cycles per slot with all enables low.
module seg_scan_driver #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 1024,
  parameter int unsigned BLANK    = 2
) (
  input logic             clk,
  input logic             rst,
  seg_scan_driver_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(PRESCALE);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W:0]   BLANK_V = (CNT_W + 1)'(BLANK);

  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic [4*DIGITS-1:0] pending, pending_n;
  logic                pend_valid, pend_valid_n;
  logic [4*DIGITS-1:0] shadow, shadow_n;
  logic                wrap;
  logic                active;
  logic                zero_run;
  logic [DIGITS-1:0]   lz_blank;
  logic [3:0]          nib;
  logic [6:0]          seg_q, seg_n;
  logic                dp_q, dp_n;
  logic [DIGITS-1:0]   den_q, den_n;
  logic                ft_q;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Outputs are decoded from the next-state values so the registered
  // outputs always match the cnt/idx/shadow they are shown with.
  always_comb begin
    cnt_n        = cnt;
    idx_n        = idx;
    pending_n    = pending;
    pend_valid_n = pend_valid;
    shadow_n     = shadow;
    wrap         = 1'b0;
    active       = 1'b0;
    zero_run     = 1'b1;
    lz_blank     = '0;
    nib          = '0;
    seg_n        = '0;
    dp_n         = 1'b0;
    den_n        = '0;

    if (cnt == CNT_MAX) begin
      cnt_n = '0;
      if (idx == IDX_MAX) begin
        idx_n = '0;
        wrap  = 1'b1;
      end else begin
        idx_n = idx + IDX_W'(1);
      end
    end else begin
      cnt_n = cnt + CNT_W'(1);
    end

    // Shadow takes the old pending on the wrap edge; a coincident load
    // only refills pending and waits for the following frame.
    if (wrap && pend_valid) begin
      shadow_n = pending;
    end
    if (bus.load) begin
      pending_n    = bus.value;
      pend_valid_n = 1'b1;
    end else if (wrap) begin
      pend_valid_n = 1'b0;
    end

    // Walk from the most significant nibble down; a digit is blanked while
    // every nibble at or above it is zero. Digit 0 always shows.
    for (int unsigned i = 0; i < DIGITS; i++) begin
      zero_run = zero_run & (shadow_n[4*(DIGITS-1-i) +: 4] == 4'h0);
      lz_blank[DIGITS-1-i] = bus.blank_lz & zero_run;
    end
    lz_blank[0] = 1'b0;

    active = ({1'b0, cnt_n} >= BLANK_V);
    nib    = shadow_n[4*idx_n +: 4];
    if (active) begin
      den_n = DIGITS'(1) << idx_n;
      dp_n  = bus.dp_mask[idx_n];
      if (!lz_blank[idx_n]) begin
        seg_n = hex7(nib);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      pending    <= '0;
      pend_valid <= 1'b0;
      shadow     <= '0;
      seg_q      <= '0;
      dp_q       <= 1'b0;
      den_q      <= '0;
      ft_q       <= 1'b0;
    end else begin
      cnt        <= cnt_n;
      idx        <= idx_n;
      pending    <= pending_n;
      pend_valid <= pend_valid_n;
      shadow     <= shadow_n;
      seg_q      <= seg_n;
      dp_q       <= dp_n;
      den_q      <= den_n;
      ft_q       <= wrap;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.digit_en   = den_q;
  assign bus.frame_tick = ft_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (DIGITS=4, PRESCALE=4,
// BLANK=1). Frame-level vectors come from a table; reset, tear-free load,
// load-on-wrap and mid-frame reset are hand-written sequences.
module tb_seg_scan_driver;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned PRESCALE = 4;
  localparam int unsigned BLANK    = 1;
  localparam int          FRAME    = DIGITS * PRESCALE;

  typedef struct {
    logic [15:0] value;
    logic        lz;
    logic [3:0]  dpm;
    logic [27:0] exp_seg;   // {d3,d2,d1,d0}, 7 bits each
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_driver_if #(.DIGITS(DIGITS)) bus_if ();

  seg_scan_driver #(
    .DIGITS  (DIGITS),
    .PRESCALE(PRESCALE),
    .BLANK   (BLANK)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int checks = 0;
  int errors = 0;

  vec_t tbl [7];
  vec_t v_1234, v_a, v_b, v_zero;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 3 * FRAME; n++) begin
      @(negedge clk);
      if (bus_if.frame_tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_tick actual=timeout expected=frame_tick t=%0t", $time);
    end
  endtask

  // Called at the negedge of a frame_tick cycle; checks the whole frame
  // and returns at the negedge of its last cycle.
  task automatic check_frame(input vec_t v);
    int          slot;
    int          c;
    logic [3:0]  den;
    logic [6:0]  sg;
    logic [27:0] segs;
    segs = v.exp_seg;
    for (int k = 0; k < FRAME; k++) begin
      slot = k / PRESCALE;
      c    = k % PRESCALE;
      den  = 4'b0001 << slot;
      sg   = segs[7*slot +: 7];
      chk("frame_tick", 32'(bus_if.frame_tick), 32'(k == 0));
      chk("digit_en", 32'(bus_if.digit_en), (c >= BLANK) ? 32'(den) : 32'd0);
      chk("seg", 32'(bus_if.seg), (c >= BLANK) ? 32'(sg) : 32'd0);
      chk("dp", 32'(bus_if.dp), (c >= BLANK) ? 32'(v.dpm[slot]) : 32'd0);
      if (k < FRAME - 1) @(negedge clk);
    end
  endtask

  // Starts at the negedge where rst has just been released (shadow = 0,
  // blank_lz = 0, dp_mask = 0); returns in the first frame_tick cycle.
  task automatic post_reset_scan(input bit do_load);
    int         slot;
    int         c;
    logic [3:0] den;
    for (int k = 0; k < FRAME; k++) begin
      slot = k / PRESCALE;
      c    = k % PRESCALE;
      den  = 4'b0001 << slot;
      chk("rs_frame_tick", 32'(bus_if.frame_tick), 32'd0);
      chk("rs_digit_en", 32'(bus_if.digit_en), (c >= BLANK) ? 32'(den) : 32'd0);
      chk("rs_seg", 32'(bus_if.seg), (c >= BLANK) ? 32'h3F : 32'd0);
      if (do_load && k == 5) begin
        bus_if.value = 16'h1234;
        bus_if.load  = 1'b1;
      end
      if (k == 6) bus_if.load = 1'b0;
      @(negedge clk);
    end
    chk("rs_first_tick", 32'(bus_if.frame_tick), 32'd1);
  endtask

  task automatic apply_vec(input vec_t v);
    wait_tick();
    bus_if.value    = v.value;
    bus_if.blank_lz = v.lz;
    bus_if.dp_mask  = v.dpm;
    bus_if.load     = 1'b1;
    @(negedge clk);
    bus_if.load = 1'b0;
    wait_tick();
    check_frame(v);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_seg"}, 32'(bus_if.seg), 32'd0);
    chk({tag, "_dp"}, 32'(bus_if.dp), 32'd0);
    chk({tag, "_digit_en"}, 32'(bus_if.digit_en), 32'd0);
    chk({tag, "_frame_tick"}, 32'(bus_if.frame_tick), 32'd0);
  endtask

  initial begin
    tbl[0] = '{16'h00A5, 1'b1, 4'b0101, {7'h00, 7'h00, 7'h77, 7'h6D}};
    tbl[1] = '{16'h0000, 1'b1, 4'b0000, {7'h00, 7'h00, 7'h00, 7'h3F}};
    tbl[2] = '{16'h0000, 1'b0, 4'b0000, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
    tbl[3] = '{16'hCDEF, 1'b1, 4'b1010, {7'h39, 7'h5E, 7'h79, 7'h71}};
    tbl[4] = '{16'h0809, 1'b1, 4'b0001, {7'h00, 7'h7F, 7'h3F, 7'h6F}};
    tbl[5] = '{16'h0070, 1'b1, 4'b1111, {7'h00, 7'h00, 7'h07, 7'h3F}};
    tbl[6] = '{16'h6B00, 1'b0, 4'b1000, {7'h7D, 7'h7C, 7'h3F, 7'h3F}};
    v_1234 = '{16'h1234, 1'b0, 4'b0000, {7'h06, 7'h5B, 7'h4F, 7'h66}};
    v_a    = '{16'hAAAA, 1'b0, 4'b0000, {7'h77, 7'h77, 7'h77, 7'h77}};
    v_b    = '{16'hBBBB, 1'b0, 4'b0000, {7'h7C, 7'h7C, 7'h7C, 7'h7C}};
    v_zero = '{16'h0000, 1'b0, 4'b0000, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};

    // Reset held 3 cycles with a competing load: outputs stay 0.
    rst             = 1'b1;
    bus_if.value    = 16'hFFFF;
    bus_if.load     = 1'b1;
    bus_if.blank_lz = 1'b0;
    bus_if.dp_mask  = 4'hF;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst            = 1'b0;
    bus_if.load    = 1'b0;
    bus_if.value   = 16'h0000;
    bus_if.dp_mask = 4'h0;

    // First frame after reset with a mid-frame load: display stays on the
    // zero shadow, new value appears from the first frame_tick.
    post_reset_scan(1'b1);
    check_frame(v_1234);

    for (int i = 0; i < 7; i++) begin
      apply_vec(tbl[i]);
    end

    // Load AAAA mid-frame, then BBBB exactly on the wrap edge.
    wait_tick();
    bus_if.blank_lz = 1'b0;
    bus_if.dp_mask  = 4'h0;
    bus_if.value    = 16'hAAAA;
    bus_if.load     = 1'b1;
    @(negedge clk);
    bus_if.load = 1'b0;
    repeat (FRAME - 2) @(negedge clk);
    bus_if.value = 16'hBBBB;
    bus_if.load  = 1'b1;
    wait_tick();
    bus_if.load = 1'b0;
    check_frame(v_a);
    wait_tick();
    check_frame(v_b);

    // Reset in slot 2 with a load pending and another load during rst:
    // both are discarded and the scan restarts at digit 0.
    wait_tick();
    bus_if.value = 16'h5555;
    bus_if.load  = 1'b1;
    @(negedge clk);
    bus_if.load = 1'b0;
    repeat (8) @(negedge clk);
    rst          = 1'b1;
    bus_if.value = 16'h7777;
    bus_if.load  = 1'b1;
    @(negedge clk);
    chk_all_zero("midreset");
    rst         = 1'b0;
    bus_if.load = 1'b0;
    post_reset_scan(1'b0);
    check_frame(v_zero);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
